// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receive stage: assembles MSB-first words from an
// enable-qualified bit stream and queues them in a small first-word-fall-through
// FIFO with a valid/ready handshake. Reports overruns and framing errors.
module sipo_deserializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic                          serial_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clear_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {StIdle, StShift} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_last_bit;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_write;
    logic                   w_frame_restart;
    logic [WIDTH-1:0]       w_word;
    logic [WIDTH-1:0]       w_first;

    // The completing bit only pushes when it is not itself a new frame start.
    assign w_last_bit      = (r_count == CNT_W'(WIDTH - 1));
    assign w_frame_restart = (r_state == StShift) && enable && frame_start;
    assign w_push          = (r_state == StShift) && enable && !frame_start && w_last_bit;
    assign w_word          = {r_shift[WIDTH-2:0], serial_in};
    assign w_first         = {{(WIDTH-1){1'b0}}, serial_in};
    assign w_full          = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop           = data_valid && data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign w_write         = w_push && (!w_full || w_pop);

    assign data_valid = (r_level != '0);
    assign data_out   = data_valid ? r_mem[r_rd_ptr] : '0;
    assign level      = r_level;
    assign busy       = (r_state == StShift);
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

    // Bit-collection FSM: shifter, bit counter and state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_shift <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (enable && frame_start) begin
                        r_shift <= w_first;
                        r_count <= CNT_W'(1);
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    if (enable) begin
                        if (frame_start) begin
                            r_shift <= w_first;
                            r_count <= CNT_W'(1);
                        end else if (w_last_bit) begin
                            r_shift <= w_word;
                            r_count <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_shift <= w_word;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_write && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_write && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_restart) begin
                r_frame_err <= 1'b1;
            end else if (clear_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer, checked every cycle
// against a word/queue-level reference model.
module tb_sipo_deserializer;

    localparam int W = 8;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           frame_start = 1'b0;
    logic           serial_in = 1'b0;
    logic           data_ready = 1'b0;
    logic           clear_err = 1'b0;
    logic [W-1:0]   data_out;
    logic           data_valid;
    logic [$clog2(D):0] level;
    logic           busy;
    logic           overrun;
    logic           frame_err;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .level       (level),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .clear_err   (clear_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: partial word as an integer, FIFO as a queue.
    int m_q[$];
    bit m_in_word = 0;
    int m_nbits   = 0;
    int m_acc     = 0;
    bit m_ovr     = 0;
    bit m_ferr    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit fs, input bit sin,
                              input bit rdy, input bit clr);
        bit pop, push, ov, fe;
        int word;
        if (rst) begin
            m_q.delete();
            m_in_word = 0;
            m_nbits   = 0;
            m_acc     = 0;
            m_ovr     = 0;
            m_ferr    = 0;
            return;
        end
        pop  = (m_q.size() > 0) && rdy;
        push = 0;
        ov   = 0;
        fe   = 0;
        word = 0;
        if (en) begin
            if (fs) begin
                if (m_in_word) fe = 1;
                m_acc     = int'(sin);
                m_nbits   = 1;
                m_in_word = 1;
            end else if (m_in_word) begin
                m_acc = m_acc * 2 + int'(sin);
                m_nbits++;
                if (m_nbits == W) begin
                    push      = 1;
                    word      = m_acc % (1 << W);
                    m_in_word = 0;
                    m_nbits   = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < D) m_q.push_back(word);
            else ov = 1;
        end
        m_ovr  = ov ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_ferr = fe ? 1'b1 : (clr ? 1'b0 : m_ferr);
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input bit rst, input bit en, input bit fs, input bit sin,
                        input bit rdy, input bit clr);
        @(negedge clk);
        reset       = rst;
        enable      = en;
        frame_start = fs;
        serial_in   = sin;
        data_ready  = rdy;
        clear_err   = clr;
        model_step(rst, en, fs, sin, rdy, clr);
        @(posedge clk);
        #1;
        check_eq("data_valid", 32'(data_valid), 32'(m_q.size() > 0));
        check_eq("data_out", 32'(data_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        check_eq("level", 32'(level), 32'(m_q.size()));
        check_eq("busy", 32'(busy), 32'(m_in_word));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        check_eq("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy, 0);
    endtask

    // Send a word MSB first; optional idle cycle between bits; ready on last bit separately.
    task automatic send_word(input logic [W-1:0] v, input bit gaps, input bit rdy,
                             input bit rdy_last);
        for (int b = W - 1; b >= 0; b--) begin
            step(0, 1, b == W - 1, v[b], (b == 0) ? rdy_last : rdy, 0);
            if (gaps && b != 0) step(0, 0, 0, 1'($urandom_range(0, 1)), rdy, 0);
        end
    endtask

    initial begin
        // Reset held two cycles.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        check_eq("reset_level", 32'(level), 32'd0);

        // Single word, consumer ready: valid for exactly one cycle.
        send_word(8'hA5, 0, 1, 1);
        check_eq("a5_head", 32'(data_out), 32'h0A5);
        idle(2, 1);

        // Same word with enable low every other cycle.
        send_word(8'hA5, 1, 1, 1);
        idle(2, 1);

        // Three words with no consumer: third dropped.
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        send_word(8'h33, 0, 0, 0);
        check_eq("ovr_level", 32'(level), 32'd2);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        idle(4, 1);
        step(0, 0, 0, 0, 0, 1);

        // Full FIFO with a pop coinciding with the completing bit.
        send_word(8'h44, 0, 0, 0);
        send_word(8'h55, 0, 0, 0);
        send_word(8'h66, 0, 0, 1);
        check_eq("fullpop_level", 32'(level), 32'd2);
        check_eq("fullpop_ovr", 32'(overrun), 32'd0);
        idle(4, 1);

        // Frame restart after three bits.
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        send_word(8'h3C, 0, 0, 0);
        check_eq("ferr_set", 32'(frame_err), 32'd1);
        check_eq("ferr_word", 32'(data_out), 32'h03C);
        step(0, 0, 0, 0, 1, 1);
        check_eq("ferr_clr", 32'(frame_err), 32'd0);

        // Reset mid-word.
        step(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1'($urandom_range(0, 1)), 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        idle(W + 2, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 11) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
